// File: rtl/logic_cluster.sv
// logic_cluster: a cluster of NUM_LE logic elements (LUT + output flop with INIT value and
// comb/registered output select) sharing one serial configuration chain. A frame-checking
// load FSM only makes the cluster ACTIVE after exactly one full frame has been shifted in.
// Optional carry logic per LE is enabled by defining the macro LE_CARRY_EN.
module logic_cluster #(
    parameter int unsigned LUT_INPUTS = 4,
    parameter int unsigned NUM_LE     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         config_en,
    input  logic                         config_data_in,
    output logic                         config_data_out,
    input  logic [NUM_LE-1:0]            le_en,
    input  logic [NUM_LE*LUT_INPUTS-1:0] select,
    output logic [NUM_LE-1:0]            le_out,
    output logic                         config_done,
    output logic                         config_error
`ifdef LE_CARRY_EN
    ,
    input  logic                         carry_in,
    output logic                         carry_out
`endif
);

    localparam int unsigned LUT_SIZE  = 2 ** LUT_INPUTS;
    localparam int unsigned MODE_POS  = LUT_SIZE;
    localparam int unsigned INIT_POS  = LUT_SIZE + 1;
`ifdef LE_CARRY_EN
    localparam int unsigned CARRY_POS = LUT_SIZE + 2;
    localparam int unsigned LE_BITS   = LUT_SIZE + 3;
`else
    localparam int unsigned LE_BITS   = LUT_SIZE + 2;
`endif
    localparam int unsigned FRAME_BITS = NUM_LE * LE_BITS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StUnconf,
        StLoading,
        StActive,
        StError
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   chain_q, chain_d;
    logic [NUM_LE-1:0]       dff_q, dff_d;

    logic                    shift;
    logic                    active;
    logic                    load_done;
    logic [LUT_SIZE-1:0]     lut [NUM_LE];
    logic [NUM_LE-1:0]       mode;
    logic [NUM_LE-1:0]       init;
    logic [NUM_LE-1:0]       mux_out;
    logic [NUM_LE-1:0]       fn_out;

    assign shift           = en & config_en;
    assign active          = (state_q == StActive);
    assign config_done     = active;
    assign config_error    = (state_q == StError);
    assign config_data_out = chain_q[FRAME_BITS-1];

    // Slice the configuration chain into per-LE fields and evaluate each LUT.
    always_comb begin
        mode    = '0;
        init    = '0;
        mux_out = '0;
        for (int unsigned i = 0; i < NUM_LE; i++) begin
            lut[i]     = chain_q[i*LE_BITS +: LUT_SIZE];
            mode[i]    = chain_q[i*LE_BITS + MODE_POS];
            init[i]    = chain_q[i*LE_BITS + INIT_POS];
            mux_out[i] = lut[i][select[i*LUT_INPUTS +: LUT_INPUTS]];
        end
    end

`ifdef LE_CARRY_EN
    // Ripple carry through the LEs; carry-enabled LEs split the LUT into propagate (low half)
    // and generate (high half) tables addressed by the low K-1 select bits.
    always_comb begin
        logic                  c;
        logic                  p;
        logic                  g;
        logic [LUT_INPUTS-2:0] lo_idx;
        fn_out = '0;
        c      = carry_in;
        p      = 1'b0;
        g      = 1'b0;
        lo_idx = '0;
        for (int unsigned i = 0; i < NUM_LE; i++) begin
            lo_idx = select[i*LUT_INPUTS +: (LUT_INPUTS-1)];
            p      = lut[i][{1'b0, lo_idx}];
            g      = lut[i][{1'b1, lo_idx}];
            if (chain_q[i*LE_BITS + CARRY_POS]) begin
                fn_out[i] = p ^ c;
                c         = p ? c : g;
            end else begin
                fn_out[i] = mux_out[i];
                c         = 1'b0;
            end
        end
        carry_out = active ? c : 1'b0;
    end
`else
    assign fn_out = mux_out;
`endif

    // Load FSM, bit counter and chain shifting; nothing advances while en is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chain_d = chain_q;
        if (shift) begin
            chain_d = {chain_q[FRAME_BITS-2:0], config_data_in};
            if (state_q != StLoading) begin
                state_d = StLoading;
                cnt_d   = CNT_ONE;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (en && (state_q == StLoading)) begin
            state_d = (cnt_q == CNT_FULL) ? StActive : StError;
        end
    end

    assign load_done = (state_q == StLoading) && (state_d == StActive);

    // User flops: INIT on load completion, capture LE function when enabled in ACTIVE.
    always_comb begin
        dff_d = dff_q;
        for (int unsigned i = 0; i < NUM_LE; i++) begin
            if (load_done) begin
                dff_d[i] = init[i];
            end else if (active && en && le_en[i]) begin
                dff_d[i] = fn_out[i];
            end
        end
    end

    // Output select; outputs are forced low outside ACTIVE.
    always_comb begin
        le_out = '0;
        for (int unsigned i = 0; i < NUM_LE; i++) begin
            le_out[i] = active & (mode[i] ? dff_q[i] : fn_out[i]);
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StUnconf;
            cnt_q   <= '0;
            chain_q <= '0;
            dff_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chain_q <= chain_d;
            dff_q   <= dff_d;
        end
    end

endmodule

// File: tb/tb_logic_cluster.sv
// tb_logic_cluster: directed bench for logic_cluster (K=4, NUM_LE=2) with a frame-level
// behavioural model checked on every negative clock edge. Define LE_CARRY_EN for the carry test.
module tb_logic_cluster;

    localparam int K     = 4;
    localparam int NLE   = 2;
    localparam int LUTSZ = 16;
`ifdef LE_CARRY_EN
    localparam int LBITS = LUTSZ + 3;
`else
    localparam int LBITS = LUTSZ + 2;
`endif
    localparam int FB = NLE * LBITS;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           config_en;
    logic           config_data_in;
    logic           config_data_out;
    logic [NLE-1:0] le_en;
    logic [NLE*K-1:0] select;
    logic [NLE-1:0] le_out;
    logic           config_done;
    logic           config_error;
`ifdef LE_CARRY_EN
    logic           carry_in;
    logic           carry_out;
`endif

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    logic_cluster #(
        .LUT_INPUTS(K),
        .NUM_LE    (NLE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .config_en      (config_en),
        .config_data_in (config_data_in),
        .config_data_out(config_data_out),
        .le_en          (le_en),
        .select         (select),
        .le_out         (le_out),
        .config_done    (config_done),
        .config_error   (config_error)
`ifdef LE_CARRY_EN
        ,
        .carry_in       (carry_in),
        .carry_out      (carry_out)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist holds every bit shifted since reset; the newest bit sits at chain position 0.
    bit       hist[$];
    int       m_st;   // 0 unconfigured, 1 loading, 2 active, 3 error
    int       m_cnt;
    bit [NLE-1:0] m_dff;

    function automatic bit cbit(int q);
        if (q < hist.size()) return hist[hist.size()-1-q];
        return 1'b0;
    endfunction

    function automatic bit fld(int le, int pos);
        return cbit(le * LBITS + pos);
    endfunction

    // Function value of every LE for the current select/carry inputs, plus the final carry.
    function automatic void eval(output bit [NLE-1:0] f, output bit co);
        bit c;
        int s;
        f = '0;
`ifdef LE_CARRY_EN
        c = carry_in;
`else
        c = 1'b0;
`endif
        for (int i = 0; i < NLE; i++) begin
            s = int'(select[i*K +: K]);
`ifdef LE_CARRY_EN
            if (fld(i, LUTSZ + 2)) begin
                bit p, g;
                p    = fld(i, s % (LUTSZ/2));
                g    = fld(i, LUTSZ/2 + s % (LUTSZ/2));
                f[i] = p ^ c;
                c    = p ? c : g;
            end else begin
                f[i] = fld(i, s);
                c    = 1'b0;
            end
`else
            f[i] = fld(i, s);
`endif
        end
        co = c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with the inputs that the
    // next rising edge will sample (inputs only change shortly after rising edges).
    always @(negedge clk) begin
        bit [NLE-1:0] f;
        bit [NLE-1:0] exp_le;
        bit co;
        if (chk_on) begin
            eval(f, co);
            for (int i = 0; i < NLE; i++)
                exp_le[i] = (m_st == 2) ? (fld(i, LUTSZ) ? m_dff[i] : f[i]) : 1'b0;
            check("model_le_out", le_out, exp_le);
            check("model_done", config_done, m_st == 2);
            check("model_error", config_error, m_st == 3);
            check("model_cdo", config_data_out, cbit(FB - 1));
`ifdef LE_CARRY_EN
            check("model_carry_out", carry_out, (m_st == 2) ? co : 1'b0);
`endif
        end
        if (rst) begin
            hist.delete();
            m_st  = 0;
            m_cnt = 0;
            m_dff = '0;
        end else if (en) begin
            eval(f, co);
            if (m_st == 2)
                for (int i = 0; i < NLE; i++) if (le_en[i]) m_dff[i] = f[i];
            if (config_en) begin
                hist.push_back(config_data_in);
                if (m_st != 1) begin
                    m_st  = 1;
                    m_cnt = 1;
                end else if (m_cnt < FB + 1) begin
                    m_cnt++;
                end
            end else if (m_st == 1) begin
                if (m_cnt == FB) begin
                    m_st = 2;
                    for (int i = 0; i < NLE; i++) m_dff[i] = fld(i, LUTSZ + 1);
                end else begin
                    m_st = 3;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [LBITS-1:0] mk_le(bit ini, bit md, logic [15:0] lt);
        logic [LBITS-1:0] v;
        v = LBITS'({ini, md, lt});
        return v;
    endfunction

    task automatic shift_bits(input logic [FB-1:0] fr, input int lo, input int hi);
        config_en = 1'b1;
        for (int k = lo; k < hi; k++) begin
            config_data_in = (k < FB) ? fr[FB-1-k] : 1'b0;
            cyc();
        end
    endtask

    task automatic drop();
        config_en      = 1'b0;
        config_data_in = 1'b0;
        cyc();
    endtask

    task automatic load_n(input logic [FB-1:0] fr, input int n);
        shift_bits(fr, 0, n);
        drop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FB-1:0] fr;
        int first;
        rst = 1'b1; en = 1'b1; config_en = 1'b0; config_data_in = 1'b0;
        le_en = '0; select = '0;
`ifdef LE_CARRY_EN
        carry_in = 1'b0;
`endif
        cyc();
        cyc();
        chk_on = 1'b1;

        // Reset state
        check("rst_le_out", le_out, 0);
        check("rst_done", config_done, 0);
        check("rst_error", config_error, 0);
        check("rst_cdo", config_data_out, 0);
        rst = 1'b0;
        select = 8'hFF;
        #1 check("rst_le_sel", le_out, 0);

        // Combinational load: LE1 = AND4 (0x8000), LE0 = XOR4 (0x6996)
        fr = {mk_le(0, 0, 16'h8000), mk_le(0, 0, 16'h6996)};
        load_n(fr, FB);
        check("comb_done", config_done, 1);
        select = 8'hFF;
        #1 check("comb_sel_ff", le_out, 2'b10);
        select = 8'h11;
        #1 check("comb_sel_11", le_out, 2'b01);
        cyc();

        // config_en toggle with en low has no effect
        en = 1'b0; config_en = 1'b1; cyc();
        config_en = 1'b0; cyc();
        en = 1'b1; cyc();
        check("toggle_done", config_done, 1);
        check("toggle_le", le_out, 2'b01);

        // Reconfigure from ACTIVE: LE1 registered INIT0 LUT 0x8000, LE0 registered INIT1 LUT 0
        fr = {mk_le(0, 1, 16'h8000), mk_le(1, 1, 16'h0000)};
        select = 8'hF0;
        config_en = 1'b1; config_data_in = fr[FB-1]; cyc();
        check("reconf_le_zero", le_out, 0);
        check("reconf_done_low", config_done, 0);
        shift_bits(fr, 1, FB);
        drop();
        check("reg_init", le_out, 2'b01);
        check("reg_done", config_done, 1);
        cyc();
        check("reg_hold", le_out, 2'b01);
        le_en = 2'b11; cyc();
        check("reg_capture", le_out, 2'b10);
        le_en = 2'b00; select = 8'h00; cyc();
        check("reg_hold2", le_out, 2'b10);
        load_n(fr, FB);
        check("reg_reload_init", le_out, 2'b01);

        // Frame length errors, then recovery
        load_n(fr, FB - 1);
        check("short_error", config_error, 1);
        check("short_le", le_out, 0);
        load_n(fr, FB + 1);
        check("long_error", config_error, 1);
        load_n(fr, FB);
        check("recover_done", config_done, 1);

        // en low while loading freezes the counter
        shift_bits(fr, 0, 10);
        en = 1'b0; cyc(); cyc(); cyc();
        check("enlow_not_done", config_done, 0);
        en = 1'b1;
        shift_bits(fr, 10, FB);
        drop();
        check("enlow_done", config_done, 1);
        check("enlow_le", le_out, 2'b01);

        // Reset in the middle of a load
        shift_bits(fr, 0, 20);
        rst = 1'b1; config_en = 1'b0; cyc();
        rst = 1'b0;
        check("midrst_cdo", config_data_out, 0);
        check("midrst_done", config_done, 0);
        check("midrst_error", config_error, 0);
        cyc();
        check("midrst_stays_unconf", config_done, 0);
        load_n(fr, FB);
        check("midrst_reload", config_done, 1);

        // Daisy chain: a single 1 emerges after FB shifts
        rst = 1'b1; cyc(); rst = 1'b0;
        first = -1;
        config_en = 1'b1;
        for (int n = 1; n <= FB + 4; n++) begin
            config_data_in = (n == 1);
            cyc();
            if (config_data_out === 1'b1 && first < 0) first = n;
        end
        check("daisy_emerge", first, FB);
        drop();
        check("daisy_overrun_error", config_error, 1);

`ifdef LE_CARRY_EN
        // Adder bits: p = a^b (0x66 low half), g = a&b (0x88 high half); 2'b11 + 2'b01 + 1
        begin
            logic [LBITS-1:0] le;
            le = mk_le(0, 0, 16'h8866);
            le[LUTSZ+2] = 1'b1;
            fr = {le, le};
        end
        carry_in = 1'b1;
        select   = 8'h13;
        load_n(fr, FB);
        #1;
        check("carry_sum", le_out, 2'b01);
        check("carry_out", carry_out, 1);
        carry_in = 1'b0;
        #1 check("carry_sum_cin0", le_out, 2'b00);
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/logic_cluster.md
# logic_cluster

Parametrised cluster of `NUM_LE` logic elements, each with a `2^LUT_INPUTS`-entry LUT, an output flop with per-LE init value, and selectable combinational/registered output. All LEs share one serial configuration chain, managed by a frame-checking load state machine. The cluster is the next-generation tile primitive under the switch/connection boxes: one clock domain for both configuration and user logic, and no hi-z outputs.

## Interface
- `LUT_INPUTS`, 4: LUT select width K; LUT holds 2^K bits.
- `NUM_LE`, 4: logic elements in the cluster.
- `clk` input 1: single clock for configuration and user flops.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: global enable; low freezes shifting, counting, state and user flops.
- `config_en` input 1: configuration shift enable.
- `config_data_in` input 1: serial configuration bit.
- `config_data_out` input/output: output 1; MSB of the chain, for daisy-chaining clusters.
- `le_en` input NUM_LE: per-LE user flop enable.
- `select` input NUM_LE*K: LE i uses `select[i*K +: K]`.
- `le_out` output NUM_LE: LE outputs.
- `config_done` output 1: high in ACTIVE.
- `config_error` output 1: high in ERROR.

## Operation
- Per-LE frame, MSB→LSB: `[INIT | MODE | LUT[2^K-1:0]]`, giving `LE_BITS = 2^K+2`. `FRAME_BITS = NUM_LE*LE_BITS`.
- Chain order:
  - A shift moves every chain bit up one position.
  - `config_data_in` enters bit 0 of LE0; LE i MSB feeds LE i+1 bit 0.
  - `config_data_out` is the MSB of LE NUM_LE-1, so the first bit shifted lands in the last LE's INIT.
- A shift occurs on a cycle with `en && config_en`.
- Bit counter: width `$clog2(FRAME_BITS+2)`; increments per shift and saturates at FRAME_BITS+1.
- States: UNCONF (reset), LOADING, ACTIVE, ERROR.
  - UNCONF/ACTIVE/ERROR → LOADING on a shift cycle. The counter is set to 1 on that cycle.
  - LOADING, `en && !config_en`: go to ACTIVE if counter == FRAME_BITS, else ERROR.
  - LOADING holds while shifting.
- LUT: `mux_out[i] = LUT_i[select_i]`.
- `le_out[i]`:
  - 0 unless state == ACTIVE.
  - In ACTIVE: `MODE ? dff[i] : mux_out[i]`.
- User flop `dff[i]`:
  - Loaded with `INIT_i` on the LOADING→ACTIVE transition cycle.
  - In ACTIVE with `en && le_en[i]`: `dff[i] <= mux_out[i]`.
  - Otherwise holds.
- Reset: chain, counter and dffs go to 0; state goes to UNCONF.

## Timing
- Reset values: `le_out`=0, `config_done`=0, `config_error`=0, `config_data_out`=0.
- Combinational mode: `select`→`le_out` is a zero-cycle path.
- Registered mode: `le_out` reflects `mux_out` sampled at the previous qualifying edge.
- `config_done` rises the cycle after the `config_en` fall is sampled. `le_out` is valid (INIT for registered LEs) in that same cycle.
- `config_data_out` changes one cycle after each shift. A bit emerges FRAME_BITS shifts after entry.
- Boundary behaviour:
  - Over-length load (more than FRAME_BITS shifts): counter saturates, then ERROR.
  - Zero-length toggle of `config_en` while `en` is low: no effect.
  - Reconfiguring from ACTIVE: `le_out` drops to 0 on the first shift cycle's next edge. User flop contents are discarded and INIT is reloaded on completion.
  - `rst` mid-load: clears everything and returns to UNCONF. A partial frame never becomes ACTIVE.
  - `en` low during LOADING with `config_en` high: holds and does not count.

## Configuration
- `LE_CARRY_EN`: adds carry logic.
  - Extra ports: `carry_in` input 1 and `carry_out` output 1.
  - Adds a CARRY bit per LE, placed above INIT: `LE_BITS = 2^K+3`.
  - With CARRY=1:
    - `p` = low LUT half indexed by `select_i[K-2:0]`; `g` = high half, same index.
    - `sum = p ^ cin`, `cout = p ? cin : g`.
    - `sum` replaces `mux_out` (both comb and registered paths).
  - With CARRY=0: `cout = 0`.
  - Chaining: LE0 `cin` = `carry_in`, LE i `cin` = LE i-1 `cout`, `carry_out` = last LE's `cout`. `carry_out` is 0 unless ACTIVE.
- Without the macro: no carry ports and `LE_BITS = 2^K+2`.

## Test plan
Parameters for all scenarios: K=4, NUM_LE=2, macro off, so FRAME_BITS=36.
- **Reset:** hold `rst` 2 cycles → all outputs 0, state UNCONF. `le_out`=0 for any `select`.
- **Comb load:**
  - Stimulus: shift 36 bits so LE1 = INIT0/MODE0/LUT 0x8000 and LE0 = INIT0/MODE0/LUT 0x6996, then drop `config_en`.
  - Response: `config_done`=1 next cycle. `select`=0xF_F → `le_out`=2'b10; `select`=0x1_1 → 2'b01, same cycle.
- **Registered/INIT:**
  - Stimulus: LE0 configured INIT=1, MODE=1, LUT=0x0000.
  - Response: after load `le_out[0]`=1. One `le_en[0]` cycle → 0. With `le_en[0]`=0 it holds 1.
- **Frame errors:** shift 35 bits then drop → `config_error`=1, `le_out`=0. Shifting 37 bits also gives ERROR. A following correct 36-bit load reaches ACTIVE.
- **Daisy chain:** shift pattern 1 followed by 0s → `config_data_out` goes high exactly 36 shifts after the 1 was applied.
- **Reset mid-load:** assert `rst` after 20 shifts → UNCONF, `config_data_out`=0. A subsequent 36-bit load succeeds.
- **Carry (macro on, LE_BITS=19):** both LEs CARRY=1 configured as an adder bit (p = a^b, g = a&b), `carry_in`=1, operands 2'b11+2'b01 → sums 2'b01, `carry_out`=1.
